// File: rtl/mem_access_seq.sv
// Single-transaction sequencer between the SLC-3 MAR/MDR datapath and the I/O bridge CPU bus.
// Accepts one request, holds the bus for RD_WAIT+1 cycles, then pulses resp_valid.
module mem_access_seq #(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ena,
  output logic              mem_wr_ena,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_ena_q, mem_ena_d;
  logic                mem_wr_ena_q, mem_wr_ena_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_ena_d    = mem_ena_q;
    mem_wr_ena_d = mem_wr_ena_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d      = ACCESS;
          cnt_d        = 4'(RD_WAIT);
          we_d         = req_we;
          mem_addr_d   = req_addr;
          mem_wdata_d  = req_wdata;
          mem_ena_d    = 1'b1;
          mem_wr_ena_d = req_we;
        end
      end
      ACCESS: begin
        // Bus strobes drop on the same edge that raises resp_valid, so DONE never drives the bus.
        if (cnt_q == '0) begin
          state_d      = DONE;
          mem_ena_d    = 1'b0;
          mem_wr_ena_d = 1'b0;
          resp_valid_d = 1'b1;
          if (!we_q) resp_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_ena_q    <= 1'b0;
      mem_wr_ena_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_ena_q    <= mem_ena_d;
      mem_wr_ena_q <= mem_wr_ena_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_ena    = mem_ena_q;
  assign mem_wr_ena = mem_wr_ena_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: RD_WAIT=2 instance plus an RD_WAIT=0 instance,
// with a minimal bridge hex register modelled on the CPU bus.
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_we, resp_valid, busy;
  logic [15:0] req_addr, req_wdata, resp_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ena, mem_wr_ena;

  logic        req1_valid, req1_ready, req1_we, resp1_valid, busy1;
  logic [15:0] req1_addr, req1_wdata, resp1_rdata;
  logic [15:0] mem1_addr, mem1_wdata, mem1_rdata;
  logic        mem1_ena, mem1_wr_ena;

  logic [15:0] hex_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_seq #(.RD_WAIT(2), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_ena(mem_ena), .mem_wr_ena(mem_wr_ena),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_seq #(.RD_WAIT(0), .ADDR_W(16), .DATA_W(16)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req1_valid), .req_ready(req1_ready), .req_we(req1_we),
    .req_addr(req1_addr), .req_wdata(req1_wdata),
    .resp_valid(resp1_valid), .resp_rdata(resp1_rdata), .busy(busy1),
    .mem_addr(mem1_addr), .mem_ena(mem1_ena), .mem_wr_ena(mem1_wr_ena),
    .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata)
  );

  // Bridge behaviour at 0xFFFF: hex register captures write data while the bus writes.
  always_ff @(posedge clk) begin
    if (reset) hex_q <= '0;
    else if (mem_ena && mem_wr_ena && mem_addr == 16'hFFFF) hex_q <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (resp_valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic seen_gap, seen_resp;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; mem1_rdata = '0;
    step(); step();

    // Reset state, with a request presented during reset
    req_valid = 1'b1; req_addr = 16'h0099;
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'h0);
    check("rst_mem_ena", 32'(mem_ena), 32'd0);
    check("rst_mem_wr_ena", 32'(mem_wr_ena), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    req_valid = 1'b0;
    reset = 1'b0;
    step();
    check("idle_after_rst", 32'(busy), 32'd0);

    // Read 0x0010, RD_WAIT=2
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; mem_rdata = 16'hBEEF;
    step();  // E0
    req_valid = 1'b0;
    check("rd_e0_ena", 32'(mem_ena), 32'd1);
    check("rd_e0_wr", 32'(mem_wr_ena), 32'd0);
    check("rd_e0_addr", 32'(mem_addr), 32'h0010);
    check("rd_e0_ready", 32'(req_ready), 32'd0);
    check("rd_e0_busy", 32'(busy), 32'd1);
    step();  // E1
    check("rd_e1_ena", 32'(mem_ena), 32'd1);
    step();  // E2
    check("rd_e2_ena", 32'(mem_ena), 32'd1);
    check("rd_e2_rv", 32'(resp_valid), 32'd0);
    step();  // E3
    check("rd_e3_ena", 32'(mem_ena), 32'd0);
    check("rd_e3_rv", 32'(resp_valid), 32'd1);
    check("rd_e3_rdata", 32'(resp_rdata), 32'hBEEF);
    check("rd_e3_ready", 32'(req_ready), 32'd0);
    step();  // E4
    check("rd_e4_rv", 32'(resp_valid), 32'd0);
    check("rd_e4_ready", 32'(req_ready), 32'd1);

    // Write 0x1234 to 0xFFFF
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'h1234;
    mem_rdata = 16'hDEAD;
    step();
    req_valid = 1'b0;
    check("wr_e0_wr", 32'(mem_wr_ena), 32'd1);
    step();
    check("wr_e1_wr", 32'(mem_wr_ena), 32'd1);
    step();
    check("wr_e2_wr", 32'(mem_wr_ena), 32'd1);
    check("wr_e2_wdata", 32'(mem_wdata), 32'h1234);
    step();
    check("wr_e3_wr", 32'(mem_wr_ena), 32'd0);
    check("wr_e3_rv", 32'(resp_valid), 32'd1);
    check("wr_rdata_kept", 32'(resp_rdata), 32'hBEEF);
    step();
    check("wr_hex", 32'(hex_q), 32'h1234);
    check("wr_addr_held", 32'(mem_addr), 32'hFFFF);
    check("wr_wdata_held", 32'(mem_wdata), 32'h1234);

    // Back-to-back: read 0x0001 then write 0x0002 with req_valid held
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0001; mem_rdata = 16'h0101;
    step();  // first accept
    check("b2b_first_addr", 32'(mem_addr), 32'h0001);
    req_we = 1'b1; req_addr = 16'h0002; req_wdata = 16'h5555;
    n = -1; seen_gap = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!mem_ena) seen_gap = 1'b1;
      if (mem_addr == 16'h0002) begin
        n = i;
        break;
      end
    end
    req_valid = 1'b0;
    check("b2b_period", 32'(n), 32'd5);
    check("b2b_gap", 32'(seen_gap), 32'd1);
    check("b2b_second_wr", 32'(mem_wr_ena), 32'd1);
    wait_resp(n);
    check("b2b_second_lat", 32'(n), 32'd3);
    check("b2b_rdata", 32'(resp_rdata), 32'h0101);
    step();

    // Late data: rdata changes in the middle ACCESS cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0020; mem_rdata = 16'h1111;
    step();  // E0
    req_valid = 1'b0;
    step();  // E1
    mem_rdata = 16'h2222;
    step();  // E2
    step();  // E3
    check("late_rv", 32'(resp_valid), 32'd1);
    check("late_rdata", 32'(resp_rdata), 32'h2222);
    mem_rdata = 16'h3333;
    step();
    step();
    check("late_hold", 32'(resp_rdata), 32'h2222);

    // Reset in the 2nd ACCESS cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; mem_rdata = 16'h4444;
    step();  // E0
    req_valid = 1'b0;
    step();  // E1: second ACCESS cycle
    reset = 1'b1;
    step();
    check("abort_ena", 32'(mem_ena), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(resp_rdata), 32'h0);
    check("abort_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    seen_resp = resp_valid;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_valid) seen_resp = 1'b1;
    end
    check("abort_no_resp", 32'(seen_resp), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0030; mem_rdata = 16'h0C0C;
    step();
    req_valid = 1'b0;
    wait_resp(n);
    check("post_abort_lat", 32'(n), 32'd3);
    check("post_abort_rdata", 32'(resp_rdata), 32'h0C0C);
    step();

    // RD_WAIT=0 instance: read 0x0005
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0005; mem1_rdata = 16'h00A5;
    step();  // E0
    req1_valid = 1'b0;
    check("rw0_e0_ena", 32'(mem1_ena), 32'd1);
    check("rw0_e0_addr", 32'(mem1_addr), 32'h0005);
    step();  // E1
    check("rw0_e1_ena", 32'(mem1_ena), 32'd0);
    check("rw0_e1_rv", 32'(resp1_valid), 32'd1);
    check("rw0_e1_rdata", 32'(resp1_rdata), 32'h00A5);
    step();  // E2
    check("rw0_e2_rv", 32'(resp1_valid), 32'd0);
    check("rw0_e2_ready", 32'(req1_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
